mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Byte-serial memory controller between the RAM port and the two cache-side clients: the instruction fetch unit (always word reads) and the data cache (byte/half/word loads and stores).
- Arbitrates the two clients and splits each access into 1/2/4 sequential byte transfers.
- Assembles and sign/zero-extends load data.
- Honours the IO buffer back-pressure and pipeline flush.

Parameters:
- ADDR_W, 32, address width of clients and RAM.
- IO_ADDR_BIT, 17, address bits [IO_ADDR_BIT:IO_ADDR_BIT-1] == 2'b11 marks an IO access.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state holds
- clr  in  1  pipeline flush (misprediction)
- IF_sgn_in  in  1  fetch request, level, held until IF_sgn_out
- IF_addr  in  32  fetch word address
- IF_sgn_out  out  1  one-cycle done pulse for fetch
- IF_val_out  out  32  fetched word, valid with IF_sgn_out
- DC_sgn_in  in  1  data request, level, held until DC_sgn_out
- DC_addr  in  32  data byte address
- DC_val_in  in  32  store data (low 8/16/32 bits used)
- DC_opcode  in  6  `LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW from the shared defines header
- DC_sgn_out  out  1  one-cycle done pulse for data
- DC_val_out  out  32  extended load result, valid with DC_sgn_out; 0 for stores
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  IO output buffer full

Behaviour:
- Reset: state IDLE; mem_a=0, mem_dout=0, mem_wr=0, IF_sgn_out=0, IF_val_out=0, DC_sgn_out=0, DC_val_out=0; byte counter=0; assembly buffer=0.
- rst has priority over rdy and clr. When rdy=0 and rst=0, every register holds, including mem_wr and the done pulses.
- States: IDLE, BUSY, COOL.
- IDLE arbitration, evaluated at each edge: a data request has priority over a fetch request.
  - A data store to an IO address is not accepted while io_buffer_full=1. A pending fetch may be accepted instead.
  - No request is accepted at an edge where clr=1.
- Byte count n: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW and fetch. Byte order is little-endian; byte k goes to address addr+k (32-bit wrap).
- Acceptance edge E0: register mem_a=addr, mem_wr=is_store, mem_dout=store byte 0. Latch source, opcode, address and data. Go to BUSY.
- Read, edges E1..E(n-1): mem_a=addr+k; capture mem_din as byte k-1.
- Read, edge En: capture byte n-1, mem_wr=0, mem_a=0.
  - Fetch: IF_val_out=assembled word, IF_sgn_out=1.
  - Load: DC_val_out=extended value, DC_sgn_out=1.
  - Go to COOL.
- Write, edges E1..E(n-1): mem_a=addr+k, mem_dout=store byte k, mem_wr=1.
- Write, edge En: mem_wr=0, mem_a=0, DC_sgn_out=1, DC_val_out=0. Go to COOL.
- Latency: the done pulse is visible in the cycle after En, i.e. n edges after acceptance.
- COOL lasts exactly one cycle: done pulses drop to 0 and no request is accepted. Then IDLE. This lets requesters drop their level request, and lets io_buffer_full update after an IO write.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW/fetch pass through.
- clr=1 in BUSY with a fetch or load in flight: abort at that edge. mem_wr=0, mem_a=0, no done pulse, go to IDLE.
- clr=1 in BUSY with a store in flight: ignored; the store completes normally.
- clr=1 during COOL: no effect.
- Done pulses are exactly one cycle wide when rdy=1. A request is never served twice.

Test Plan:
- Reset then idle: all outputs 0 for 5 cycles; no RAM write.
- Fetch at 0x00000010, RAM bytes 0x13,0x05,0x00,0x00 at 0x10..0x13 → mem_a steps 0x10..0x13 on consecutive edges; IF_val_out=0x00000513 with a 1-cycle IF_sgn_out 4 edges after acceptance.
- LB at 0x100 holding 0x80 → DC_val_out=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x200 holding 0x34,0x92 → 0xFFFF9234.
- SW of 0xDEADBEEF to 0x400 → mem_wr=1 for 4 edges with mem_dout EF,BE,AD,DE at 0x400..0x403; then DC_sgn_out pulse, then a COOL cycle.
- Fetch and load raised in the same cycle → load served first; fetch accepted after COOL. SB to 0x30000 with io_buffer_full=1 is held; it is accepted the edge after io_buffer_full falls.
- clr raised on E2 of an LW → no DC_sgn_out, controller back in IDLE. clr raised on E2 of an SW → all 4 bytes written and the done pulse issued. rdy=0 for 3 cycles mid-LW → latency extends by 3; result unchanged.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bundle of the client-side request/response signals and the byte-wide RAM port.
// The controller uses the slave view; the surrounding clients and RAM use the master view.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);

  // Instruction fetch client
  logic              IF_sgn_in;
  logic [ADDR_W-1:0] IF_addr;
  logic              IF_sgn_out;
  logic [31:0]       IF_val_out;

  // Data cache client
  logic              DC_sgn_in;
  logic [ADDR_W-1:0] DC_addr;
  logic [31:0]       DC_val_in;
  logic [5:0]        DC_opcode;
  logic              DC_sgn_out;
  logic [31:0]       DC_val_out;

  // RAM byte port and IO back-pressure
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  IF_sgn_in, IF_addr,
    output IF_sgn_out, IF_val_out,
    input  DC_sgn_in, DC_addr, DC_val_in, DC_opcode,
    output DC_sgn_out, DC_val_out,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output IF_sgn_in, IF_addr,
    input  IF_sgn_out, IF_val_out,
    output DC_sgn_in, DC_addr, DC_val_in, DC_opcode,
    input  DC_sgn_out, DC_val_out,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and data-cache requests, splits each
// access into 1/2/4 sequential RAM byte transfers, assembles and extends load data.
module mem_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned IO_ADDR_BIT = 17,
  // Data-cache opcode encodings, overridable to match the shared defines
  parameter logic [5:0]  OpLb        = 6'd1,
  parameter logic [5:0]  OpLh        = 6'd2,
  parameter logic [5:0]  OpLw        = 6'd3,
  parameter logic [5:0]  OpLbu       = 6'd4,
  parameter logic [5:0]  OpLhu       = 6'd5,
  parameter logic [5:0]  OpSb        = 6'd6,
  parameter logic [5:0]  OpSh        = 6'd7,
  parameter logic [5:0]  OpSw        = 6'd8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      clr,
  mem_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StCool = 2'd2;

  localparam logic SrcIf = 1'b0;
  localparam logic SrcDc = 1'b1;

  // Number of bytes moved by a data-cache opcode; unknown opcodes behave as a word.
  function automatic logic [2:0] op_bytes(input logic [5:0] op);
    logic [2:0] n;
    case (op)
      OpLb, OpLbu, OpSb: n = 3'd1;
      OpLh, OpLhu, OpSh: n = 3'd2;
      default:           n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

  // Sign/zero extension of an assembled little-endian load.
  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] raw);
    logic [31:0] v;
    case (op)
      OpLb:    v = {{24{raw[7]}}, raw[7:0]};
      OpLh:    v = {{16{raw[15]}}, raw[15:0]};
      OpLbu:   v = {24'h0, raw[7:0]};
      OpLhu:   v = {16'h0, raw[15:0]};
      default: v = raw;
    endcase
    return v;
  endfunction

  // Transaction state
  logic [1:0]        state_q, state_d;
  logic              src_q, src_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [31:0]       asm_q, asm_d;

  // Registered outputs
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_sgn_q, if_sgn_d;
  logic [31:0]       if_val_q, if_val_d;
  logic              dc_sgn_q, dc_sgn_d;
  logic [31:0]       dc_val_q, dc_val_d;

  // Decode helpers
  logic              dc_is_store;
  logic              dc_is_io;
  logic              dc_ok;
  logic              cur_store;
  logic              last_byte;
  logic [1:0]        rd_idx;
  logic [31:0]       asm_nxt;
  logic [7:0]        store_byte;
  logic [ADDR_W-1:0] next_addr;

  // Request qualification and per-byte datapath helpers.
  always_comb begin
    dc_is_store = op_is_store(bus.DC_opcode);
    dc_is_io    = (bus.DC_addr[IO_ADDR_BIT -: 2] == 2'b11);
    // IO stores wait for room in the IO buffer; everything else goes straight through.
    dc_ok       = bus.DC_sgn_in && !(dc_is_store && dc_is_io && bus.io_buffer_full);
    cur_store   = (src_q == SrcDc) && op_is_store(op_q);
    last_byte   = (cnt_q == nbytes_q);
    rd_idx      = 2'(cnt_q - 3'd1);
    asm_nxt     = asm_q;
    asm_nxt[{rd_idx, 3'b000} +: 8] = bus.mem_din;
    store_byte  = data_q[{cnt_q[1:0], 3'b000} +: 8];
    next_addr   = addr_q + ADDR_W'(cnt_q);
  end

  // Next-state logic for the arbiter and byte sequencer.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    asm_d      = asm_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_val_d   = if_val_q;
    dc_val_d   = dc_val_q;
    // Done strobes are single-cycle: they only rise on the final byte edge.
    if_sgn_d   = 1'b0;
    dc_sgn_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (!clr && dc_ok) begin
          state_d    = StBusy;
          src_d      = SrcDc;
          op_d       = bus.DC_opcode;
          addr_d     = bus.DC_addr;
          data_d     = bus.DC_val_in;
          nbytes_d   = op_bytes(bus.DC_opcode);
          cnt_d      = 3'd1;
          asm_d      = 32'h0;
          mem_a_d    = bus.DC_addr;
          mem_wr_d   = dc_is_store;
          mem_dout_d = bus.DC_val_in[7:0];
        end else if (!clr && bus.IF_sgn_in) begin
          state_d    = StBusy;
          src_d      = SrcIf;
          op_d       = OpLw;
          addr_d     = bus.IF_addr;
          data_d     = 32'h0;
          nbytes_d   = 3'd4;
          cnt_d      = 3'd1;
          asm_d      = 32'h0;
          mem_a_d    = bus.IF_addr;
          mem_wr_d   = 1'b0;
          mem_dout_d = 8'h0;
        end
      end

      StBusy: begin
        if (cur_store) begin
          // Stores are never flushed: a half-written location would be worse than the
          // wasted cycles.
          if (last_byte) begin
            state_d  = StCool;
            mem_wr_d = 1'b0;
            mem_a_d  = '0;
            dc_sgn_d = 1'b1;
            dc_val_d = 32'h0;
          end else begin
            mem_a_d    = next_addr;
            mem_dout_d = store_byte;
            mem_wr_d   = 1'b1;
            cnt_d      = cnt_q + 3'd1;
          end
        end else if (clr) begin
          // Flushed read: drop it without a done strobe.
          state_d  = StIdle;
          mem_wr_d = 1'b0;
          mem_a_d  = '0;
        end else begin
          asm_d = asm_nxt;
          if (last_byte) begin
            state_d  = StCool;
            mem_wr_d = 1'b0;
            mem_a_d  = '0;
            if (src_q == SrcIf) begin
              if_val_d = asm_nxt;
              if_sgn_d = 1'b1;
            end else begin
              dc_val_d = extend(op_q, asm_nxt);
              dc_sgn_d = 1'b1;
            end
          end else begin
            mem_a_d = next_addr;
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end

      StCool: begin
        // One quiet cycle so the served requester can drop its level request.
        state_d = StIdle;
      end

      default: begin
        state_d  = StIdle;
        mem_wr_d = 1'b0;
        mem_a_d  = '0;
      end
    endcase
  end

  // State registers: synchronous reset first, then hold everything while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      src_q      <= SrcIf;
      op_q       <= 6'h0;
      addr_q     <= '0;
      data_q     <= 32'h0;
      cnt_q      <= 3'd0;
      nbytes_q   <= 3'd0;
      asm_q      <= 32'h0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'h0;
      mem_wr_q   <= 1'b0;
      if_sgn_q   <= 1'b0;
      if_val_q   <= 32'h0;
      dc_sgn_q   <= 1'b0;
      dc_val_q   <= 32'h0;
    end else if (rdy) begin
      state_q    <= state_d;
      src_q      <= src_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      asm_q      <= asm_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_sgn_q   <= if_sgn_d;
      if_val_q   <= if_val_d;
      dc_sgn_q   <= dc_sgn_d;
      dc_val_q   <= dc_val_d;
    end
  end

  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = mem_dout_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.IF_sgn_out = if_sgn_q;
  assign bus.IF_val_out = if_val_q;
  assign bus.DC_sgn_out = dc_sgn_q;
  assign bus.DC_val_out = dc_val_q;

endmodule
